// File: rtl/lcd_wave_render_pkg.sv
// Shared LCD definitions: RGB565 colours, pixel width, default panel size and sample-to-row mapping.
package lcd_wave_render_pkg;

  localparam int PIX_W       = 16;
  localparam int H_VALID_DEF = 800;
  localparam int V_VALID_DEF = 480;

  localparam logic [PIX_W-1:0] RGB_BLACK  = 16'h0000;
  localparam logic [PIX_W-1:0] RGB_GREY   = 16'h4208;
  localparam logic [PIX_W-1:0] RGB_YELLOW = 16'hFFE0;

  // Larger samples sit higher on screen; 255 lands on y_offset, 0 lands on y_offset+255.
  function automatic logic [10:0] sample_row(input logic [10:0] y_offset, input logic [7:0] s);
    return y_offset + 11'd255 - {3'b000, s};
  endfunction

endpackage

// File: rtl/lcd_grid_gen.sv
// Graticule generator: gx/gy counters track x mod GRID_X and y mod GRID_Y without dividers.
// Combinational hit for the current S1 pixel; counters advance only on active pixels.
module lcd_grid_gen #(
  parameter int H_VALID = 800,
  parameter int V_VALID = 480,
  parameter int GRID_X  = 100,
  parameter int GRID_Y  = 60
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_de,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  output logic        o_grid_hit
);

  localparam int GX_W = $clog2(GRID_X + 1);
  localparam int GY_W = $clog2(GRID_Y + 1);

  logic [GX_W-1:0] r_gx, w_gx;
  logic [GY_W-1:0] r_gy, w_gy;
  logic            w_last_col;

  // Line/frame starts override the stored count so stale state never leaks across lines.
  assign w_gx       = (i_x == 11'd0) ? '0 : r_gx;
  assign w_gy       = (i_y == 11'd0) ? '0 : r_gy;
  assign w_last_col = (i_x == 11'(H_VALID - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gx <= '0;
      r_gy <= '0;
    end else if (i_de) begin
      r_gx <= (w_gx == GX_W'(GRID_X - 1)) ? '0 : w_gx + GX_W'(1);
      if (w_last_col)
        r_gy <= (w_gy == GY_W'(GRID_Y - 1)) ? '0 : w_gy + GY_W'(1);
    end
  end

  assign o_grid_hit = (w_gx == '0) || (w_gy == '0) || w_last_col ||
                      (i_y == 11'(V_VALID - 1));

endmodule

// File: rtl/lcd_wave_render.sv
// Scope pixel renderer: connected waveform trace over a graticule, RGB565 out.
// Fixed 2-cycle latency on rgb/hs/vs/de; no stalls, one pixel per clock.
module lcd_wave_render
  import lcd_wave_render_pkg::*;
#(
  parameter int               H_VALID  = H_VALID_DEF,
  parameter int               V_VALID  = V_VALID_DEF,
  parameter int               ADDR_W   = 10,
  parameter int               Y_OFFSET = 112,
  parameter int               GRID_X   = 100,
  parameter int               GRID_Y   = 60,
  parameter logic [PIX_W-1:0] C_BG     = RGB_BLACK,
  parameter logic [PIX_W-1:0] C_GRID   = RGB_GREY,
  parameter logic [PIX_W-1:0] C_WAVE   = RGB_YELLOW
)(
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              h_de,
  input  logic              v_de,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [PIX_W-1:0]  lcd_rgb,
  output logic              frame_end
);

  logic        w_de_in;
  logic        r_de, r_hs, r_vs;
  logic [10:0] r_x, r_y, r_y_prev;
  logic [10:0] w_y_cur, w_y_ref, w_lo, w_hi;
  logic        w_trace_hit, w_grid_hit, w_last_pix;

  assign w_de_in     = h_de & v_de;
  assign ram_rd_addr = w_de_in ? pixel_xpos[ADDR_W-1:0] : '0;

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_de <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
    end else begin
      r_de <= w_de_in;
      r_hs <= hs_in;
      r_vs <= vs_in;
      r_x  <= pixel_xpos;
      r_y  <= pixel_ypos;
    end
  end

  // RAM data arriving now belongs to the column held in S1.
  assign w_y_cur     = sample_row(11'(Y_OFFSET), ram_rd_data);
  assign w_y_ref     = (r_x == 11'd0) ? w_y_cur : r_y_prev;
  assign w_lo        = (w_y_ref < w_y_cur) ? w_y_ref : w_y_cur;
  assign w_hi        = (w_y_ref < w_y_cur) ? w_y_cur : w_y_ref;
  assign w_trace_hit = (r_y >= w_lo) && (r_y <= w_hi);
  assign w_last_pix  = r_de && (r_x == 11'(H_VALID - 1)) && (r_y == 11'(V_VALID - 1));

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst)
      r_y_prev <= '0;
    else if (r_de)
      r_y_prev <= w_y_cur;
  end

  lcd_grid_gen #(
    .H_VALID (H_VALID),
    .V_VALID (V_VALID),
    .GRID_X  (GRID_X),
    .GRID_Y  (GRID_Y)
  ) u_grid (
    .i_clk      (lcd_clk),
    .i_rst      (sys_rst),
    .i_de       (r_de),
    .i_x        (r_x),
    .i_y        (r_y),
    .o_grid_hit (w_grid_hit)
  );

  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lcd_hs    <= 1'b0;
      lcd_vs    <= 1'b0;
      lcd_de    <= 1'b0;
      lcd_rgb   <= '0;
      frame_end <= 1'b0;
    end else begin
      lcd_hs    <= r_hs;
      lcd_vs    <= r_vs;
      lcd_de    <= r_de;
      frame_end <= w_last_pix;
      if (!r_de)
        lcd_rgb <= '0;
      else if (w_trace_hit)
        lcd_rgb <= C_WAVE;
      else if (w_grid_hit)
        lcd_rgb <= C_GRID;
      else
        lcd_rgb <= C_BG;
    end
  end

endmodule

// File: tb/tb_lcd_wave_render.sv
// Scoreboarded bench for lcd_wave_render on a reduced panel: flat, step and random traces,
// sync alignment, frame_end counting and a mid-line asynchronous reset.
module tb_lcd_wave_render;

  localparam int H_VALID  = 40;
  localparam int V_VALID  = 264;
  localparam int ADDR_W   = 6;
  localparam int Y_OFFSET = 4;
  localparam int GRID_X   = 10;
  localparam int GRID_Y   = 24;
  localparam int H_TOTAL  = H_VALID + 4;
  localparam int V_TOTAL  = V_VALID + 4;
  localparam logic [15:0] C_BG   = 16'h0841;
  localparam logic [15:0] C_GRID = 16'h4208;
  localparam logic [15:0] C_WAVE = 16'hFFE0;

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fe;
    logic [15:0] rgb;
  } exp_t;

  logic              lcd_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              hs_in = 1'b0, vs_in = 1'b0, h_de = 1'b0, v_de = 1'b0;
  logic [10:0]       pixel_xpos = '0, pixel_ypos = '0;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [7:0]        ram_rd_data = '0;
  logic              lcd_hs, lcd_vs, lcd_de, frame_end;
  logic [15:0]       lcd_rgb;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   fe_count = 0;
  int   samples [H_VALID];
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  lcd_wave_render #(
    .H_VALID(H_VALID), .V_VALID(V_VALID), .ADDR_W(ADDR_W), .Y_OFFSET(Y_OFFSET),
    .GRID_X(GRID_X), .GRID_Y(GRID_Y), .C_BG(C_BG), .C_GRID(C_GRID), .C_WAVE(C_WAVE)
  ) dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .hs_in(hs_in), .vs_in(vs_in),
    .h_de(h_de), .v_de(v_de), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .frame_end(frame_end)
  );

  always #5 lcd_clk = ~lcd_clk;
  always @(posedge lcd_clk) cyc <= cyc + 1;
  always @(posedge lcd_clk) ram_rd_data <= mem[ram_rd_addr];

  function automatic int row_of(input int s);
    return Y_OFFSET + 255 - s;
  endfunction

  // Reference picture: trace segment between this column's row and the previous column's row.
  function automatic logic [15:0] colour(input int x, input int y);
    int cur, prev, lo, hi;
    cur  = row_of(samples[x]);
    prev = (x == 0) ? cur : row_of(samples[x-1]);
    lo   = (cur < prev) ? cur : prev;
    hi   = (cur < prev) ? prev : cur;
    if (y >= lo && y <= hi) return C_WAVE;
    if ((x % GRID_X) == 0 || (y % GRID_Y) == 0 || x == H_VALID-1 || y == V_VALID-1)
      return C_GRID;
    return C_BG;
  endfunction

  task automatic drive(input int c, input int r, input logic rst_val);
    logic        hd, vd, de;
    logic [10:0] x, y;
    logic [ADDR_W-1:0] exp_addr;
    exp_t        e;
    hd = (c < H_VALID);
    vd = (r < V_VALID);
    de = hd & vd;
    x  = hd ? 11'(c) : 11'($urandom_range(0, 2047));
    y  = vd ? 11'(r) : 11'($urandom_range(0, 2047));
    @(posedge lcd_clk);
    #1;
    sys_rst    = rst_val;
    hs_in      = !(c >= H_VALID+1 && c < H_VALID+3);
    vs_in      = (r == V_VALID+1);
    h_de       = hd;
    v_de       = vd;
    pixel_xpos = x;
    pixel_ypos = y;
    e.due = cyc + 2;
    if (rst_val) begin
      e.hs = 0; e.vs = 0; e.de = 0; e.fe = 0; e.rgb = '0;
    end else begin
      e.hs  = hs_in;
      e.vs  = vs_in;
      e.de  = de;
      e.fe  = de && c == H_VALID-1 && r == V_VALID-1;
      e.rgb = de ? colour(c, r) : 16'h0000;
    end
    sb.push_back(e);
    #1;
    exp_addr = de ? x[ADDR_W-1:0] : '0;
    checks++;
    if (ram_rd_addr !== exp_addr) begin
      failures++;
      $display("FAIL ram_rd_addr cyc=%0d got=%0d exp=%0d", cyc, ram_rd_addr, exp_addr);
    end
  endtask

  always @(negedge lcd_clk) begin
    if (frame_end === 1'b1) fe_count++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.due != cyc ||
          {lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb} !==
          {mon_e.hs, mon_e.vs, mon_e.de, mon_e.fe, mon_e.rgb}) begin
        failures++;
        $display("FAIL pixel cyc=%0d due=%0d got hs=%b vs=%b de=%b fe=%b rgb=%h exp hs=%b vs=%b de=%b fe=%b rgb=%h",
                 cyc, mon_e.due, lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb,
                 mon_e.hs, mon_e.vs, mon_e.de, mon_e.fe, mon_e.rgb);
      end
    end
  end

  initial begin
    logic hold_rst;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom_range(0, 255));
    #2;
    checks++;
    if ({lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb});
    end
    hold_rst = 1'b1;
    for (int c = 0; c < 8; c++) drive(c, V_VALID, hold_rst);
    hold_rst = 1'b0;

    for (int f = 0; f < 4; f++) begin
      for (int x = 0; x < H_VALID; x++) begin
        case (f)
          0:       samples[x] = 128;
          1:       samples[x] = (x < H_VALID/2) ? 0 : 255;
          default: samples[x] = $urandom_range(0, 255);
        endcase
      end
      if (f == 3) begin
        samples[1] = 0;
        samples[2] = 255;
      end
      for (int x = 0; x < H_VALID; x++) mem[x] = 8'(samples[x]);

      for (int r = 0; r < V_TOTAL; r++) begin
        for (int c = 0; c < H_TOTAL; c++) begin
          if (f == 2 && r == V_VALID+2 && c == 0) hold_rst = 1'b0;
          drive(c, r, hold_rst);
          if (f == 2 && r == 100 && c == 17) begin
            #1;
            sys_rst  = 1'b1;
            hold_rst = 1'b1;
            #1;
            checks++;
            if ({lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb} !== 20'h0) begin
              failures++;
              $display("FAIL async_reset got=%h exp=0", {lcd_hs, lcd_vs, lcd_de, frame_end, lcd_rgb});
            end
            for (int i = 0; i < sb.size(); i++) begin
              sb[i].hs = 0; sb[i].vs = 0; sb[i].de = 0; sb[i].fe = 0; sb[i].rgb = '0;
            end
          end
        end
      end
    end

    for (int c = 0; c < 4; c++) drive(c, V_VALID, 1'b0);
    repeat (3) @(negedge lcd_clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    checks++;
    if (fe_count != 3) begin
      failures++;
      $display("FAIL frame_end_count got=%0d exp=3", fe_count);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
